// File: rtl/port_ctl_pkg.sv
// Shared constants for the CPU port controller: port map, register bit positions
// and interrupt vectors.
package port_ctl_pkg;

  localparam logic [7:0] PortData     = 8'h00;
  localparam logic [7:0] PortStatus   = 8'h01;
  localparam logic [7:0] PortFrameAck = 8'h02;
  localparam logic [7:0] PortBorder   = 8'hFE;

  localparam int unsigned StatNonEmpty = 0;
  localparam int unsigned StatOverflow = 1;
  localparam int unsigned StatFrame    = 2;
  localparam int unsigned StatKbdEn    = 3;
  localparam int unsigned StatFrameEn  = 4;

  localparam int unsigned CtrlKbdEn   = 0;
  localparam int unsigned CtrlFrameEn = 1;
  localparam int unsigned CtrlOvfClr  = 6;
  localparam int unsigned CtrlFlush   = 7;

  localparam logic [7:0] VecKbd   = 8'hCF;
  localparam logic [7:0] VecFrame = 8'hD7;
  localparam logic [7:0] VecNone  = 8'hFF;

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard byte FIFO. A push while full is dropped unless a pop happens in the same cycle;
// flush empties the FIFO but keeps a same-cycle push.
module kbd_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned Aw = $clog2(Depth);
  localparam int unsigned Cw = Aw + 1;

  logic [7:0]    mem_q [Depth];
  logic [Aw-1:0] rd_q, wr_q;
  logic [Cw-1:0] count_q;
  logic          do_push, do_pop, mem_we;
  logic [Aw-1:0] mem_waddr;

  assign empty = (count_q == '0);
  assign full  = (count_q == Cw'(Depth));
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    mem_we    = flush ? push : do_push;
    mem_waddr = flush ? '0 : wr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_q    <= '0;
      wr_q    <= push ? Aw'(1) : '0;
      count_q <= push ? Cw'(1) : '0;
    end else begin
      if (do_push) wr_q <= wr_q + Aw'(1);
      if (do_pop)  rd_q <= rd_q + Aw'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + Cw'(1);
        2'b01:   count_q <= count_q - Cw'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) mem_q[mem_waddr] <= din;
  end

endmodule

// File: rtl/port_ctl.sv
// CPU I/O port controller: keyboard FIFO, frame interrupt, border colour register and
// RST-vector interrupt generation.
module port_ctl
  import port_ctl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] port_a,
  input  logic [7:0] port_o,
  input  logic       port_we,
  input  logic       port_rd,
  output logic [7:0] port_in,
  input  logic       iff1,
  output logic       irq,
  output logic [7:0] irq_vec,
  input  logic       kdone,
  input  logic [7:0] ascii,
  input  logic       vs,
  output logic [2:0] border
);

  logic       kbd_en_q, frame_en_q, overflow_q, frame_pend_q, vs_prev_q;
  logic [2:0] border_q;
  logic [7:0] fifo_head, status;
  logic       fifo_full, fifo_empty;
  logic       pop_req, wr_ctrl, wr_ack, wr_border, flush, ovf_set, frame_set;
  logic       kbd_src, frame_src;
  logic       unused_port_o;

  assign unused_port_o = ^port_o[5:3];

  always_comb begin
    pop_req   = port_rd && (port_a == PortData);
    wr_ctrl   = port_we && (port_a == PortStatus);
    wr_ack    = port_we && (port_a == PortFrameAck);
    wr_border = port_we && (port_a == PortBorder);
    flush     = wr_ctrl && port_o[CtrlFlush];
    // A full FIFO only overflows if nothing makes room this cycle.
    ovf_set   = kdone && fifo_full && !pop_req && !flush;
    frame_set = vs_prev_q && !vs;
  end

  kbd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_kbd_fifo (
    .clock (clock),
    .reset (reset),
    .push  (kdone),
    .pop   (pop_req),
    .flush (flush),
    .din   (ascii),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      kbd_en_q     <= 1'b0;
      frame_en_q   <= 1'b0;
      overflow_q   <= 1'b0;
      frame_pend_q <= 1'b0;
      vs_prev_q    <= 1'b1;
      border_q     <= '0;
    end else begin
      vs_prev_q <= vs;
      if (wr_ctrl) begin
        kbd_en_q   <= port_o[CtrlKbdEn];
        frame_en_q <= port_o[CtrlFrameEn];
      end
      if (ovf_set) overflow_q <= 1'b1;
      else if (wr_ctrl && port_o[CtrlOvfClr]) overflow_q <= 1'b0;
      frame_pend_q <= frame_set || (frame_pend_q && !wr_ack);
      if (wr_border) border_q <= port_o[2:0];
    end
  end

  always_comb begin
    status               = '0;
    status[StatNonEmpty] = !fifo_empty;
    status[StatOverflow] = overflow_q;
    status[StatFrame]    = frame_pend_q;
    status[StatKbdEn]    = kbd_en_q;
    status[StatFrameEn]  = frame_en_q;

    case (port_a)
      PortData:   port_in = fifo_empty ? 8'h00 : fifo_head;
      PortStatus: port_in = status;
      default:    port_in = 8'hFF;
    endcase

    kbd_src   = kbd_en_q && !fifo_empty;
    frame_src = frame_en_q && frame_pend_q;
    irq       = iff1 && (kbd_src || frame_src);
    if (kbd_src)        irq_vec = VecKbd;
    else if (frame_src) irq_vec = VecFrame;
    else                irq_vec = VecNone;
  end

  assign border = border_q;

endmodule

// File: tb/tb_port_ctl.sv
// Directed self-checking bench for port_ctl with hand-computed expectations.
module tb_port_ctl;

  logic       clock = 1'b0;
  logic       reset, port_we, port_rd, iff1, kdone, vs, irq;
  logic [7:0] port_a, port_o, port_in, irq_vec, ascii, val;
  logic [2:0] border;

  int checks = 0;
  int errors = 0;

  port_ctl #(
    .FIFO_DEPTH (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .port_a  (port_a),
    .port_o  (port_o),
    .port_we (port_we),
    .port_rd (port_rd),
    .port_in (port_in),
    .iff1    (iff1),
    .irq     (irq),
    .irq_vec (irq_vec),
    .kdone   (kdone),
    .ascii   (ascii),
    .vs      (vs),
    .border  (border)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    kdone = 1'b1;
    ascii = b;
    tick();
    kdone = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_a  = a;
    port_o  = d;
    port_we = 1'b1;
    tick();
    port_we = 1'b0;
  endtask

  task automatic pop();
    port_a  = 8'h00;
    port_rd = 1'b1;
    tick();
    port_rd = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    port_a = a;
    #1;
    d = port_in;
  endtask

  initial begin
    reset = 1'b1; port_we = 1'b0; port_rd = 1'b0; iff1 = 1'b0; kdone = 1'b0;
    vs = 1'b1; port_a = 8'h00; port_o = 8'h00; ascii = 8'h00;
    tick(); tick();
    reset = 1'b0;

    check_eq("rst_irq", {7'b0, irq}, 8'h00);
    check_eq("rst_vec", irq_vec, 8'hFF);
    rd(8'h00, val); check_eq("rst_data", val, 8'h00);
    rd(8'h01, val); check_eq("rst_status", val, 8'h00);
    check_eq("rst_border", {5'b0, border}, 8'h00);
    rd(8'h55, val); check_eq("undef_port", val, 8'hFF);

    // Basic push/pop
    push(8'h41); push(8'h42);
    rd(8'h01, val); check_eq("two_status", val, 8'h01);
    rd(8'h00, val); check_eq("head_41", val, 8'h41);
    pop();
    rd(8'h00, val); check_eq("head_42", val, 8'h42);
    pop();
    rd(8'h01, val); check_eq("empty_status", val, 8'h00);
    rd(8'h00, val); check_eq("empty_data", val, 8'h00);
    pop();
    rd(8'h01, val); check_eq("pop_empty", val, 8'h00);

    // Overflow: ninth byte dropped
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    rd(8'h01, val); check_eq("ovf_status", val, 8'h03);
    for (int i = 0; i < 8; i++) begin
      rd(8'h00, val); check_eq($sformatf("ovf_rd%0d", i), val, 8'h10 + 8'(i));
      pop();
    end
    rd(8'h01, val); check_eq("ovf_drained", val, 8'h02);
    wr(8'h01, 8'h40);
    rd(8'h01, val); check_eq("ovf_clear", val, 8'h00);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    kdone = 1'b1; ascii = 8'h30; port_a = 8'h00; port_rd = 1'b1;
    tick();
    kdone = 1'b0; port_rd = 1'b0;
    rd(8'h01, val); check_eq("full_pushpop_status", val, 8'h01);
    for (int i = 0; i < 8; i++) begin
      rd(8'h00, val);
      check_eq($sformatf("full_rd%0d", i), val, (i == 7) ? 8'h30 : 8'h21 + 8'(i));
      pop();
    end
    rd(8'h01, val); check_eq("full_drained", val, 8'h00);

    // Flush coinciding with a push keeps only the new byte
    push(8'h50); push(8'h51);
    kdone = 1'b1; ascii = 8'h60;
    wr(8'h01, 8'h80);
    kdone = 1'b0;
    rd(8'h00, val); check_eq("flush_push_head", val, 8'h60);
    pop();
    rd(8'h01, val); check_eq("flush_push_empty", val, 8'h00);

    // Interrupts: keyboard over frame
    wr(8'h01, 8'h03);
    iff1 = 1'b1;
    vs = 1'b0; tick(); tick();
    vs = 1'b1; tick();
    push(8'h77);
    check_eq("irq_both", {7'b0, irq}, 8'h01);
    check_eq("vec_kbd", irq_vec, 8'hCF);
    rd(8'h01, val); check_eq("irq_status", val, 8'h1D);
    pop();
    check_eq("irq_frame", {7'b0, irq}, 8'h01);
    check_eq("vec_frame", irq_vec, 8'hD7);
    wr(8'h02, 8'hA5);
    check_eq("irq_cleared", {7'b0, irq}, 8'h00);
    check_eq("vec_none", irq_vec, 8'hFF);
    rd(8'h01, val); check_eq("ack_status", val, 8'h18);

    // Frame set wins over same-cycle acknowledge
    vs = 1'b0;
    wr(8'h02, 8'h00);
    rd(8'h01, val); check_eq("set_wins", val, 8'h1C);
    check_eq("irq_set_wins", {7'b0, irq}, 8'h01);
    iff1 = 1'b0; #1;
    check_eq("irq_masked", {7'b0, irq}, 8'h00);
    rd(8'h01, val); check_eq("masked_status", val, 8'h1C);
    vs = 1'b1; tick();

    // Border and reset override
    wr(8'hFE, 8'hFD);
    check_eq("border", {5'b0, border}, 8'h05);
    wr(8'h10, 8'hFF);
    check_eq("undef_wr_border", {5'b0, border}, 8'h05);
    rd(8'h01, val); check_eq("undef_wr_status", val, 8'h1C);
    push(8'h33);
    reset = 1'b1; kdone = 1'b1; ascii = 8'h12; vs = 1'b0;
    tick();
    reset = 1'b0; kdone = 1'b0; vs = 1'b1;
    check_eq("rst2_border", {5'b0, border}, 8'h00);
    rd(8'h01, val); check_eq("rst2_status", val, 8'h00);
    rd(8'h00, val); check_eq("rst2_data", val, 8'h00);
    check_eq("rst2_vec", irq_vec, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_ctl.md
PORT_CTL -- requirements
Module: port_ctl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving the keyboard FIFO depth in entries; it SHALL be a power of two, range 2..64.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock (25 MHz CPU/VGA domain).
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port port_a, input, 8 bits: I/O port number from the CPU.
REQ-005 The block SHALL have port port_o, input, 8 bits: CPU write data.
REQ-006 The block SHALL have port port_we, input, 1 bit: one-cycle port-write strobe.
REQ-007 The block SHALL have port port_rd, input, 1 bit: one-cycle port-read strobe.
REQ-008 The block SHALL have port port_in, output, 8 bits: port read data to the CPU.
REQ-009 The block SHALL have port iff1, input, 1 bit: CPU interrupt-enable flag.
REQ-010 The block SHALL have port irq, output, 1 bit: interrupt request, level.
REQ-011 The block SHALL have port irq_vec, output, 8 bits: RST opcode for the pending interrupt.
REQ-012 The block SHALL have port kdone, input, 1 bit: one-cycle pulse; ascii is valid.
REQ-013 The block SHALL have port ascii, input, 8 bits: key code from the keyboard.
REQ-014 The block SHALL have port vs, input, 1 bit: VGA vertical sync, active low, same clock domain.
REQ-015 The block SHALL have port border, output, 3 bits: border colour to the VGA adapter.

Function
REQ-016 port_in SHALL be combinational from port_a and current state: 0x00 gives the FIFO head (0x00 if empty); 0x01 gives status; any other port gives 0xFF.
REQ-017 Status SHALL be: bit0 FIFO non-empty, bit1 overflow (sticky), bit2 frame pending, bit3 kbd_en, bit4 frame_en, bits7:5 = 0.
REQ-018 A clock edge with port_rd=1 and port_a=0x00 SHALL pop one FIFO entry; a pop on an empty FIFO SHALL change nothing.
REQ-019 A write to 0x01 SHALL set kbd_en=port_o[0] and frame_en=port_o[1]; port_o[6]=1 SHALL clear overflow; port_o[7]=1 SHALL empty the FIFO.
REQ-020 A write to 0x02 SHALL clear frame pending, whatever the data.
REQ-021 A write to 0xFE SHALL load border from port_o[2:0]; border SHALL be registered.
REQ-022 kdone=1 SHALL push ascii; push while full without a same-cycle pop SHALL drop the byte and set overflow.
REQ-023 Simultaneous push and pop SHALL both take effect, including when full; occupancy SHALL be unchanged and no overflow SHALL be set.
REQ-024 A flush (REQ-019) coinciding with kdone SHALL leave the FIFO holding exactly the new byte.
REQ-025 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-026 vs SHALL be registered once as vs_prev; a cycle with vs_prev=1 and vs=0 SHALL set frame pending.
REQ-027 A frame-pending set SHALL win over a same-cycle clear.
REQ-028 irq SHALL be iff1 AND ((kbd_en AND non-empty) OR (frame_en AND frame pending)), combinational, level-held until its source is cleared.
REQ-029 irq_vec SHALL be 0xCF (RST 1) when the keyboard source is active, else 0xD7 (RST 2) when the frame source is active, else 0xFF.
REQ-030 Keyboard SHALL have priority over frame.
REQ-031 Writes to undefined ports SHALL be ignored; port_rd to ports other than 0x00 SHALL have no side effect.

Reset
REQ-032 reset SHALL give: FIFO empty, pointers 0, overflow 0, frame pending 0, kbd_en 0, frame_en 0, border 0, vs_prev 1.
REQ-033 With those values, irq SHALL be 0, irq_vec 0xFF and port_in 0x00 at port 0x00.
REQ-034 reset SHALL override every same-cycle strobe, push or vs edge.
REQ-035 Reset mid-operation SHALL discard FIFO contents.

Structure
REQ-036 A shared package SHALL hold: port numbers (0x00, 0x01, 0x02, 0xFE), status bit positions, control bit positions, and the vector constants 0xCF, 0xD7, 0xFF.
REQ-037 The FIFO SHALL be one sub-module, kbd_fifo, with push/pop/flush/full/empty/overflow-free interface.
REQ-038 Overflow and the port decode SHALL live in port_ctl.

Verification
REQ-039 Reset, then push 0x41, 0x42 -> status=0x01, port_in@0x00=0x41; pop -> 0x42; pop -> status=0x00, port_in=0x00.
REQ-040 Push 9 bytes (FIFO_DEPTH=8) -> status=0x03, first 8 read back in order; write 0x01 with 0x40 -> bit1=0.
REQ-041 Full FIFO with push and pop in the same cycle -> count stays 8, no overflow, the new byte is read last.
REQ-042 Write 0x01 with 0x03, iff1=1, vs falling edge plus one key -> irq=1, irq_vec=0xCF; pop the key -> irq_vec=0xD7; write 0x02 -> irq=0.
REQ-043 Clearing frame pending in the same cycle as a vs edge -> pending stays 1; iff1=0 -> irq=0 while status bits are unaffected.
REQ-044 Write 0xFE with 0xFD -> border=3'b101; assert reset during a push -> border=0, FIFO empty.
